// File: rtl/dualport_clear_ram.sv
// dualport_clear_ram: single-clock true dual-port RAM with byte enables, registered reads,
// deterministic collision forwarding and a hardware clear sweep.
// Optional build macro DPRAM_CLEAR_ON_RESET_EN: leaving reset starts a full clear sweep.
module dualport_clear_ram #(
    parameter int               width       = 16,
    parameter int               widthad     = 10,
    parameter logic [width-1:0] clear_value = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear_req,
    output logic                 clear_busy,
    input  logic                 wren_a,
    input  logic [width/8-1:0]   byteena_a,
    input  logic [widthad-1:0]   address_a,
    input  logic [width-1:0]     data_a,
    output logic [width-1:0]     q_a,
    input  logic                 wren_b,
    input  logic [width/8-1:0]   byteena_b,
    input  logic [widthad-1:0]   address_b,
    input  logic [width-1:0]     data_b,
    output logic [width-1:0]     q_b
);

    localparam int lanes = width / 8;
    localparam int depth = 1 << widthad;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [widthad-1:0]   counter;
    logic [widthad-1:0]   counter_next;

    // Effective port A request: either the user port or the clear sequencer.
    logic                 a_en;
    logic [widthad-1:0]   a_addr;
    logic [width-1:0]     a_data;
    logic [lanes-1:0]     a_be;
    logic                 b_en;

    // Post-write contents of each port's addressed word this cycle.
    logic [width-1:0]     word_a;
    logic [width-1:0]     word_b;

    logic [width-1:0]     mem [depth];

    function automatic logic [width-1:0] merge(
        input logic [width-1:0] old_word,
        input logic [width-1:0] new_word,
        input logic [lanes-1:0] be
    );
        logic [width-1:0] result;
        result = old_word;
        for (int i = 0; i < lanes; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

`ifdef DPRAM_CLEAR_ON_RESET_EN
    localparam state_t reset_state = CLEAR;
    // The sweep is armed during reset but must not be reported until reset drops.
    assign clear_busy = (state == CLEAR) && !reset;
`else
    localparam state_t reset_state = IDLE;
    assign clear_busy = (state == CLEAR);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= reset_state;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    counter_next = '0;
                end
            end
            CLEAR: begin
                if (counter == '1) begin
                    state_next   = IDLE;
                    counter_next = '0;
                end else begin
                    counter_next = counter + widthad'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase
    end

    // Port arbitration: the sequencer takes over port A and silences port B writes.
    always_comb begin
        a_en   = wren_a;
        a_addr = address_a;
        a_data = data_a;
        a_be   = byteena_a;
        b_en   = wren_b;
        if (state == CLEAR) begin
            a_en   = 1'b1;
            a_addr = counter;
            a_data = clear_value;
            a_be   = '1;
            b_en   = 1'b0;
        end
        if (reset) begin
            a_en = 1'b0;
            b_en = 1'b0;
        end
    end

    // Port B lanes are applied first and port A lanes on top, so A wins shared lanes
    // and both ports observe the identical final word on a same-address collision.
    always_comb begin
        word_a = mem[a_addr];
        if (b_en && (address_b == a_addr)) begin
            word_a = merge(word_a, data_b, byteena_b);
        end
        if (a_en) begin
            word_a = merge(word_a, a_data, a_be);
        end

        word_b = mem[address_b];
        if (b_en) begin
            word_b = merge(word_b, data_b, byteena_b);
        end
        if (a_en && (a_addr == address_b)) begin
            word_b = merge(word_b, a_data, a_be);
        end
    end

    // NOTE: the array has no reset branch; contents survive reset and map onto plain RAM.
    always_ff @(posedge clock) begin
        if (a_en) begin
            mem[a_addr] <= word_a;
        end
        if (b_en) begin
            mem[address_b] <= word_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (state != CLEAR) begin
                q_a <= word_a;
            end
            q_b <= word_b;
        end
    end

endmodule

// File: tb/tb_dualport_clear_ram.sv
// tb_dualport_clear_ram: directed and randomized checks of dualport_clear_ram (widthad=4, width=16)
// against an array-based reference model of the RAM contents.
module tb_dualport_clear_ram;

    localparam int          DEPTH = 16;
    localparam logic [15:0] CLR   = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        clear_busy;
    logic        wren_a;
    logic [1:0]  byteena_a;
    logic [3:0]  address_a;
    logic [15:0] data_a;
    logic [15:0] q_a;
    logic        wren_b;
    logic [1:0]  byteena_b;
    logic [3:0]  address_b;
    logic [15:0] data_b;
    logic [15:0] q_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [DEPTH];
    logic [15:0] held_qa;

    dualport_clear_ram #(
        .width      (16),
        .widthad    (4),
        .clear_value(CLR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .wren_a     (wren_a),
        .byteena_a  (byteena_a),
        .address_a  (address_a),
        .data_a     (data_a),
        .q_a        (q_a),
        .wren_b     (wren_b),
        .byteena_b  (byteena_b),
        .address_b  (address_b),
        .data_b     (data_b),
        .q_b        (q_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
        for (int l = 0; l < 2; l++) begin
            if (be[l]) model[addr][8*l +: 8] = data[8*l +: 8];
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One normal (IDLE) cycle: both ports read, optional writes, reads see post-write words.
    task automatic op(input logic wa, input logic [1:0] bea, input logic [3:0] aa, input logic [15:0] da,
                      input logic wb, input logic [1:0] beb, input logic [3:0] ab, input logic [15:0] db);
        wren_a = wa; byteena_a = bea; address_a = aa; data_a = da;
        wren_b = wb; byteena_b = beb; address_b = ab; data_b = db;
        clear_req = 1'b0;
        step();
        if (wb) model_write(ab, db, beb);
        if (wa) model_write(aa, da, bea);
        check("op_q_a", q_a, model[aa]);
        check("op_q_b", q_b, model[ab]);
        check_bit("op_busy", clear_busy, 1'b0);
    endtask

    task automatic fill(input logic [15:0] value);
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 2'b11, 4'(i), value, 1'b1, 2'b11, 4'(i + 8), value);
        end
    endtask

    task automatic start_sweep(output logic [15:0] held);
        wren_a = 1'b0; wren_b = 1'b0;
        address_a = 4'($urandom); address_b = 4'($urandom);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        held = model[address_a];
        check("start_q_a", q_a, held);
        check_bit("start_busy", clear_busy, 1'b1);
    endtask

    // Sweep cycles with random port traffic that must have no effect on the array.
    task automatic sweep_cycles(input int first, input int count, input logic [15:0] held);
        for (int j = 0; j < count; j++) begin
            int k;
            k = first + j;
            wren_a = 1'b1; byteena_a = 2'($urandom); address_a = 4'($urandom); data_a = 16'($urandom);
            wren_b = 1'($urandom); byteena_b = 2'($urandom); data_b = 16'($urandom);
            address_b = (k % 2 == 0) ? 4'(k) : 4'($urandom);
            clear_req = 1'b0;
            step();
            model[k] = CLR;
            check("sweep_q_b", q_b, model[address_b]);
            check("sweep_q_a_hold", q_a, held);
            check_bit("sweep_busy", clear_busy, k < 15);
        end
    endtask

    initial begin
        // Reset with active writes and clear request: all must be ignored.
        reset = 1'b1; clear_req = 1'b1;
        wren_a = 1'b1; byteena_a = 2'b11; address_a = 4'd0; data_a = 16'h1357;
        wren_b = 1'b1; byteena_b = 2'b11; address_b = 4'd1; data_b = 16'h2468;
        repeat (3) begin
            step();
            check("rst_q_a", q_a, 16'h0000);
            check("rst_q_b", q_b, 16'h0000);
            check_bit("rst_busy", clear_busy, 1'b0);
        end
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            op(1'b1, 2'b11, 4'(i), 16'($urandom), 1'b1, 2'b11, 4'(i + 8), 16'($urandom));
        end

        // Writes during reset must not land.
        reset = 1'b1; clear_req = 1'b1;
        wren_a = 1'b1; byteena_a = 2'b11; address_a = 4'd0; data_a = ~model[0];
        wren_b = 1'b1; byteena_b = 2'b11; address_b = 4'd1; data_b = ~model[1];
        repeat (2) begin
            step();
            check("rst2_q_a", q_a, 16'h0000);
            check_bit("rst2_busy", clear_busy, 1'b0);
        end
        reset = 1'b0;
        op(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd1, 16'h0);

        // Directed test-plan cases.
        op(1'b1, 2'b11, 4'd3, 16'hBEEF, 1'b0, 2'b00, 4'd0, 16'h0);
        op(1'b0, 2'b00, 4'd3, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0);
        check("dir_beef", q_a, 16'hBEEF);
        op(1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0);
        check("dir_be34", q_a, 16'hBE34);
        op(1'b1, 2'b10, 4'd5, 16'hAAAA, 1'b1, 2'b11, 4'd5, 16'h5555);
        check("dir_coll_a", q_a, 16'hAA55);
        check("dir_coll_b", q_b, 16'hAA55);
        op(1'b0, 2'b00, 4'd5, 16'h0, 1'b0, 2'b00, 4'd5, 16'h0);
        check("dir_coll_mem", q_a, 16'hAA55);
        op(1'b1, 2'b11, 4'd7, 16'h1111, 1'b0, 2'b00, 4'd7, 16'h0);
        check("dir_fwd_b", q_b, 16'h1111);

        repeat (300) begin
            op(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
               1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom));
        end

        // Full sweep over a 0xFFFF-filled array.
        fill(16'hFFFF);
        start_sweep(held_qa);
        sweep_cycles(0, 16, held_qa);
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 2'b00, 4'(i), 16'h0, 1'b0, 2'b00, 4'(15 - i), 16'h0);
            check("swept_q_a", q_a, CLR);
            check("swept_q_b", q_b, CLR);
        end

        // clear_req held high across the end of a sweep restarts immediately.
        wren_a = 1'b0; wren_b = 1'b0; clear_req = 1'b1;
        step();
        check_bit("lvl_start", clear_busy, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step();
            check_bit("lvl_busy1", clear_busy, k < 15);
        end
        step();
        check_bit("lvl_restart", clear_busy, 1'b1);
        clear_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check_bit("lvl_busy2", clear_busy, k < 15);
        end
        op(1'b0, 2'b00, 4'd9, 16'h0, 1'b0, 2'b00, 4'd15, 16'h0);

        // Reset at sweep cycle 6 aborts, leaving 0-5 cleared.
        fill(16'hFFFF);
        start_sweep(held_qa);
        sweep_cycles(0, 6, held_qa);
        reset = 1'b1;
        step();
        check_bit("abort_busy", clear_busy, 1'b0);
        check("abort_q_a", q_a, 16'h0000);
        check("abort_q_b", q_b, 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 2'b00, 4'(i), 16'h0, 1'b0, 2'b00, 4'(i), 16'h0);
            check("abort_mem", q_a, (i < 6) ? CLR : 16'hFFFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dualport_clear_ram.md
Name: dualport_clear_ram

Overview:
- Single-clock, true dual-port, byte-enabled RAM with registered read data and a built-in clear sequencer.
- Successor to the plain dual-port RAM used for video, palette and sprite buffers.
- Adds parametrised byte lanes, deterministic collision and forwarding rules, and a hardware sweep that fills the whole array with a constant. Intended for buffers that are wiped on game reset or mode change.

Parameters:
- width, 16, data word width in bits; must be a multiple of 8.
- widthad, 10, address width; depth = 2**widthad words.
- clear_value, 0, word written to every location by the clear sequencer (width bits).

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_req  in  1  pulse or level; starts a clear sweep when sampled high in IDLE.
- clear_busy  out  1  high while the sweep is running.
- wren_a  in  1  port A write enable.
- byteena_a  in  width/8  port A byte enables; bit n gates data bits [8n+7:8n].
- address_a  in  widthad  port A address.
- data_a  in  width  port A write data.
- q_a  out  width  port A read data, registered.
- wren_b  in  1  port B write enable.
- byteena_b  in  width/8  port B byte enables.
- address_b  in  widthad  port B address.
- data_b  in  width  port B write data.
- q_b  out  width  port B read data, registered.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; sweep counter = 0.
  - clear_busy = 0, q_a = 0, q_b = 0.
  - Array contents are untouched.
  - While reset is high, writes are suppressed and clear_req is ignored.
- Read latency: 1 clock. Address presented at edge N gives q at edge N+1. Every non-reset cycle performs a read on both ports.
- Byte-enabled write: only lanes with byteena set are updated. Lanes with byteena clear keep their old contents.
- Same-port read-during-write: q returns the merged word, i.e. the new bytes in enabled lanes and the old bytes elsewhere.
- Mixed-port, same address, one port writes and the other reads: the reader gets the merged new word (forwarding). It never gets stale or undefined data.
- Both ports write the same address in the same cycle:
  - Lanes enabled on A take data_a.
  - Lanes enabled only on B take data_b.
  - q_a and q_b both return the final merged word.
- Different addresses: the two ports are fully independent.
- State machine:
  - IDLE: clear_busy = 0. If clear_req = 1, go to CLEAR next cycle with the counter at 0.
  - CLEAR, entry: clear_busy rises on the clock edge that leaves IDLE.
  - CLEAR, each cycle: write clear_value (all lanes) to address = counter, then increment the counter.
  - CLEAR, exit: when counter = 2**widthad-1 has been written, return to IDLE. clear_busy falls on that same edge. A sweep therefore takes exactly 2**widthad cycles of clear_busy high.
  - The counter is widthad bits wide. The terminal test is on all-ones and the counter never wraps during a sweep.
- During CLEAR:
  - Port A is owned by the sequencer. wren_a is ignored and q_a holds its last value.
  - Port B reads normally. wren_b is ignored.
  - A port B read of the address being cleared in that cycle returns clear_value (forwarding rule).
  - clear_req is ignored.
- clear_req held high across the end of a sweep starts a new sweep on the following cycle. It is level-sensitive in IDLE.
- Reset during CLEAR:
  - Aborts the sweep immediately; the array is left partially cleared.
  - The next cycle is IDLE with clear_busy = 0.

Optional Feature:
- Macro: DPRAM_CLEAR_ON_RESET_EN.
- Defined: deasserting reset enters CLEAR instead of IDLE. The first cycle after reset low writes address 0 and clear_busy = 1, and a full sweep runs automatically. q_a and q_b are still 0 during reset.
- Undefined: reset always lands in IDLE, and clearing happens only via clear_req.

Test Plan:
- widthad=4, width=16: write A addr 3 = 0xBEEF, read next cycle -> q_a = 0xBEEF one clock after the read address. Then write A addr 3 byteena=2'b01 data 0x1234 -> q_a = 0xBE34.
- Same cycle: A writes addr 5 = 0xAAAA with byteena 2'b10, B writes addr 5 = 0x5555 with byteena 2'b11 -> memory and both q = 0xAA55.
- A writes addr 7 = 0x1111 while B reads addr 7 -> q_b = 0x1111 on the next edge.
- Fill all 16 words with 0xFFFF, clear_value=0x0000, pulse clear_req:
  - clear_busy high for exactly 16 cycles.
  - wren_a/wren_b during the sweep have no effect.
  - Afterwards every address reads 0x0000.
- Assert reset at sweep cycle 6 -> clear_busy = 0 next cycle, addresses 0-5 read 0x0000, addresses 6-15 read 0xFFFF.
- With DPRAM_CLEAR_ON_RESET_EN: release reset -> clear_busy = 1 for 16 cycles, then all words read clear_value.
